// File: rtl/bank_rotation_sched_if.sv
// bank_rotation_sched_if: host/convolver handshake and bank control bundle (slave = scheduler, master = host)
interface bank_rotation_sched_if #(
  parameter int N          = 2,
  parameter int NB_ADDRESS = 10,
  parameter int NB_COLS    = 10
);
  localparam int NB = $clog2(N + 2);
  logic                  i_start;
  logic [NB_ADDRESS-1:0] i_img_len;
  logic [NB_COLS-1:0]    i_n_cols;
  logic                  i_wr_valid;
  logic                  i_rd_req;
  logic [N+1:0]          o_we;
  logic [NB_ADDRESS-1:0] o_waddr;
  logic [NB_ADDRESS-1:0] o_raddr;
  logic [NB-1:0]         o_base;
  logic [NB-1:0]         o_rd_sel;
  logic                  o_src_sel;
  logic                  o_conv_valid;
  logic                  o_load_rdy;
  logic                  o_rd_rdy;
  logic                  o_eop;
  modport master (
    output i_start, i_img_len, i_n_cols, i_wr_valid, i_rd_req,
    input  o_we, o_waddr, o_raddr, o_base, o_rd_sel, o_src_sel, o_conv_valid, o_load_rdy, o_rd_rdy, o_eop
  );
  modport slave (
    input  i_start, i_img_len, i_n_cols, i_wr_valid, i_rd_req,
    output o_we, o_waddr, o_raddr, o_base, o_rd_sel, o_src_sel, o_conv_valid, o_load_rdy, o_rd_rdy, o_eop
  );
endinterface

// File: rtl/bank_rotation_sched.sv
// bank_rotation_sched: rotates N+2 column banks through load/run/flush/unload per block; ports i_CLK, i_reset (async), bus (slave)
module bank_rotation_sched #(
  parameter int N          = 2,
  parameter int NB_ADDRESS = 10,
  parameter int NB_COLS    = 10,
  parameter int CONV_LAT   = 2
) (
  input logic                  i_CLK,
  input logic                  i_reset,
  bank_rotation_sched_if.slave bus
);
  localparam int B  = N + 2;
  localparam int NB = $clog2(B);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, UNLOAD, DONE} state_t;
  state_t                state_q, state_d;
  logic [NB_ADDRESS-1:0] img_len_q, img_len_d, word_q, word_d;
  logic [NB_COLS-1:0]    n_cols_q, n_cols_d, cols_done_q, cols_done_d;
  logic [NB-1:0]         base_q, base_d, k_q, k_d;
  logic                  blk_first_q, blk_first_d;
  logic [3:0]            fl_q, fl_d;
  logic                  vld_sr_q [CONV_LAT];
  logic [NB_ADDRESS-1:0] addr_sr_q [CONV_LAT];
  logic                  last_word, last_col, dv;
  logic [NB-1:0]         ld_bank;
  logic [B-1:0]          wb_mask, load_we;
  function automatic logic [NB-1:0] wrap(input logic [NB:0] s);
    logic [NB:0] t;
    t = (s >= (NB+1)'(B)) ? s - (NB+1)'(B) : s;
    return t[NB-1:0];
  endfunction
  assign last_word = word_q == img_len_q - NB_ADDRESS'(1);
  assign last_col  = k_q == (blk_first_q ? NB'(B - 1) : NB'(N - 1));
  // first block fills every bank; later blocks skip the 2 overlap banks after base
  assign ld_bank   = wrap({1'b0, base_q} + (blk_first_q ? (NB+1)'(0) : (NB+1)'(2)) + {1'b0, k_q});
  assign dv        = vld_sr_q[CONV_LAT-1];
  assign load_we   = (state_q == LOAD && bus.i_wr_valid) ? B'(1) << ld_bank : '0;
  always_comb begin
    wb_mask = '0;
    for (int i = 0; i < N; i++) wb_mask[wrap({1'b0, base_q} + (NB+1)'(i))] = 1'b1;
  end
  always_comb begin
    state_d     = state_q;
    img_len_d   = img_len_q;
    n_cols_d    = n_cols_q;
    cols_done_d = cols_done_q;
    base_d      = base_q;
    k_d         = k_q;
    word_d      = word_q;
    blk_first_d = blk_first_q;
    fl_d        = fl_q;
    case (state_q)
      IDLE: if (bus.i_start) begin
        img_len_d   = bus.i_img_len;
        n_cols_d    = bus.i_n_cols;
        cols_done_d = '0;
        base_d      = '0;
        k_d         = '0;
        word_d      = '0;
        blk_first_d = 1'b1;
        state_d     = LOAD;
      end
      LOAD: if (bus.i_wr_valid) begin
        word_d = last_word ? '0 : word_q + 1'b1;
        if (last_word) begin
          k_d     = last_col ? '0 : k_q + 1'b1;
          state_d = last_col ? RUN : LOAD;
        end
      end
      RUN: begin
        word_d = last_word ? '0 : word_q + 1'b1;
        fl_d   = '0;
        if (last_word) state_d = FLUSH;
      end
      FLUSH: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == 4'(CONV_LAT - 1)) state_d = UNLOAD;
      end
      UNLOAD: if (bus.i_rd_req) begin
        word_d = last_word ? '0 : word_q + 1'b1;
        if (last_word) begin
          k_d = (k_q == NB'(N - 1)) ? '0 : k_q + 1'b1;
          if (k_q == NB'(N - 1)) begin
            cols_done_d = cols_done_q + (blk_first_q ? NB_COLS'(B) : NB_COLS'(N));
            if (cols_done_d == n_cols_q) state_d = DONE;
            else begin
              base_d      = wrap({1'b0, base_q} + (NB+1)'(N));
              blk_first_d = 1'b0;
              state_d     = LOAD;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      img_len_q   <= '0;
      n_cols_q    <= '0;
      cols_done_q <= '0;
      base_q      <= '0;
      k_q         <= '0;
      word_q      <= '0;
      blk_first_q <= 1'b0;
      fl_q        <= '0;
      for (int i = 0; i < CONV_LAT; i++) begin
        vld_sr_q[i]  <= 1'b0;
        addr_sr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      img_len_q    <= img_len_d;
      n_cols_q     <= n_cols_d;
      cols_done_q  <= cols_done_d;
      base_q       <= base_d;
      k_q          <= k_d;
      word_q       <= word_d;
      blk_first_q  <= blk_first_d;
      fl_q         <= fl_d;
      vld_sr_q[0]  <= state_q == RUN;
      addr_sr_q[0] <= word_q;
      for (int i = 1; i < CONV_LAT; i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        addr_sr_q[i] <= addr_sr_q[i-1];
      end
    end
  end
  assign bus.o_we         = load_we | (dv ? wb_mask : '0);
  assign bus.o_waddr      = dv ? addr_sr_q[CONV_LAT-1] : (state_q == LOAD) ? word_q : '0;
  assign bus.o_raddr      = (state_q == RUN || state_q == UNLOAD) ? word_q : '0;
  assign bus.o_base       = base_q;
  assign bus.o_rd_sel     = (state_q == UNLOAD) ? wrap({1'b0, base_q} + {1'b0, k_q}) : '0;
  assign bus.o_src_sel    = dv;
  assign bus.o_conv_valid = state_q == RUN;
  assign bus.o_load_rdy   = state_q == LOAD;
  assign bus.o_rd_rdy     = state_q == UNLOAD;
  assign bus.o_eop        = state_q == DONE;
endmodule
